// File: rtl/imem_port_arbiter_pkg.sv
// imem_arb_pkg
// Shared definitions for the instruction-memory port arbiter:
//   - load-type encodings as presented on ld_req_type
//   - NOP_INSTR, the word returned for a fetch outside the memory
//   - arb_state_e, the arbiter state machine encoding
//   - isCrossing(), which tells whether a load spans two memory words
package imem_arb_pkg;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [1:0] {
    IDLE,
    FETCH_RSP,
    LD_BEAT2,
    LD_RSP
  } arb_state_e;

  // A load needs a second memory beat when its bytes run past the end of
  // the first word: any misaligned word, or a halfword starting at byte 3.
  // Byte loads and unknown types never cross.
  function automatic logic isCrossing(input logic [2:0] ldType, input logic [1:0] offset);
    case (ldType)
      LW:      return offset != 2'b00;
      LH, LHU: return offset == 2'b11;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/imem_port_arbiter_load_align_ext.sv
// load_align_ext
// Purely combinational byte-lane alignment and extension for loads.
// Ports:
//   w         in  32  first memory word read (holds the addressed byte)
//   n         in  32  next memory word (only meaningful for crossing loads)
//   offset    in  2   byte offset of the load address within w
//   load_type in  3   LB/LH/LW/LBU/LHU encoding; other codes give 0
//   result    out 32  aligned, sign- or zero-extended load value
module load_align_ext
  import imem_arb_pkg::*;
(
  input  logic [31:0] w,
  input  logic [31:0] n,
  input  logic [1:0]  offset,
  input  logic [2:0]  load_type,
  output logic [31:0] result
);

  logic [31:0] w_raw;

  // Treat {n, w} as eight little-endian bytes and slide the addressed byte
  // down to bit 0; this covers every merge case for both the single-beat and
  // the split path with one shifter.
  assign w_raw = 32'({n, w} >> {offset, 3'b000});

  // Pick the access width and extend it; unknown types return zero.
  always_comb begin
    result = '0;
    case (load_type)
      LB:      result = {{24{w_raw[7]}}, w_raw[7:0]};
      LBU:     result = {24'h000000, w_raw[7:0]};
      LH:      result = {{16{w_raw[15]}}, w_raw[15:0]};
      LHU:     result = {16'h0000, w_raw[15:0]};
      LW:      result = w_raw;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter
// Shares the single synchronous read port of the instruction memory between
// the IF-stage fetch and the MEM-stage load path. One transaction is in
// flight at a time; misaligned loads that cross a word take two beats and
// are merged before extension. Responses are registered one-cycle pulses.
// Optional build macro IMEM_ARB_STATS_EN adds 32-bit accept/split counters.
// Ports:
//   clk, rst                          clock, synchronous active-high reset
//   if_req_valid/addr/ready           fetch request handshake
//   if_rsp_valid/data                 fetch response pulse and word
//   ld_req_valid/addr/type/ready      load request handshake
//   ld_rsp_valid/data                 load response pulse and extended value
//   mem_en, mem_idx, mem_rdata        memory read port (data one cycle later)
//   stat_fetch/load/split_cnt         (IMEM_ARB_STATS_EN only) counters
module imem_port_arbiter
  import imem_arb_pkg::*;
#(
  parameter int MEM_WORDS = 512,
  parameter int MAX_WAIT  = 4,
  parameter int IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             if_req_valid,
  input  logic [31:0]      if_req_addr,
  output logic             if_req_ready,
  output logic             if_rsp_valid,
  output logic [31:0]      if_rsp_data,
  input  logic             ld_req_valid,
  input  logic [31:0]      ld_req_addr,
  input  logic [2:0]       ld_req_type,
  output logic             ld_req_ready,
  output logic             ld_rsp_valid,
  output logic [31:0]      ld_rsp_data,
  output logic             mem_en,
  output logic [IDX_W-1:0] mem_idx,
  input  logic [31:0]      mem_rdata
`ifdef IMEM_ARB_STATS_EN
  ,
  output logic [31:0]      stat_fetch_cnt,
  output logic [31:0]      stat_load_cnt,
  output logic [31:0]      stat_split_cnt
`endif
);

  localparam int CNT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);
  localparam logic [31:0] MEM_WORDS_U = 32'(MEM_WORDS);

  arb_state_e       r_state;
  arb_state_e       w_stateNext;
  logic [CNT_W-1:0] r_starveCnt;
  logic [29:0]      r_wordIdx;
  logic [1:0]       r_offset;
  logic [2:0]       r_ldType;
  logic             r_split;
  logic             r_oorFirst;
  logic             r_oorSecond;
  logic [31:0]      r_holdWord;
  logic             r_ifRspValid;
  logic [31:0]      r_ifRspData;
  logic             r_ldRspValid;
  logic [31:0]      r_ldRspData;

  logic        w_grantFetch;
  logic        w_acceptFetch;
  logic        w_acceptLoad;
  logic        w_ifOor;
  logic        w_ldOor;
  logic        w_ldCross;
  logic [30:0] w_beat2Idx;
  logic        w_beat2Oor;
  logic        w_beatOor;
  logic [31:0] w_beatData;
  logic [31:0] w_alignW;
  logic [31:0] w_alignN;
  logic [31:0] w_alignResult;
  logic        w_unusedAddrBits;

  // The fetch port is word-granular, so its two low address bits carry no
  // information; fold them into a sink so they are visibly consumed.
  assign w_unusedAddrBits = ^if_req_addr[1:0];

  // Range checks use the whole word address so that large addresses never
  // alias back into the memory through the truncated index. The second beat
  // is computed one bit wider so that the top word cannot wrap to zero.
  assign w_ifOor    = {2'b00, if_req_addr[31:2]} >= MEM_WORDS_U;
  assign w_ldOor    = {2'b00, ld_req_addr[31:2]} >= MEM_WORDS_U;
  assign w_ldCross  = isCrossing(ld_req_type, ld_req_addr[1:0]);
  assign w_beat2Idx = {1'b0, r_wordIdx} + 31'd1;
  assign w_beat2Oor = {1'b0, w_beat2Idx} >= MEM_WORDS_U;

  // A pending fetch beats a pending load only once it has waited MAX_WAIT
  // cycles; otherwise loads take priority so the MEM stage is not stalled.
  assign w_grantFetch = if_req_valid && (!ld_req_valid || (r_starveCnt == MAX_CNT));

  // Memory data for the beat being completed this cycle, with beats that
  // were outside the memory replaced by zero. In LD_RSP of a split load the
  // word arriving is the second beat; in every other state it is the first.
  assign w_beatOor  = ((r_state == LD_RSP) && r_split) ? r_oorSecond : r_oorFirst;
  assign w_beatData = w_beatOor ? 32'h00000000 : mem_rdata;

  // The aligner always sees the addressed word as w; for split loads that is
  // the word parked in r_holdWord and the live data is the following word.
  assign w_alignW = r_split ? r_holdWord : w_beatData;
  assign w_alignN = r_split ? w_beatData : 32'h00000000;

  load_align_ext u_align (
    .w         (w_alignW),
    .n         (w_alignN),
    .offset    (r_offset),
    .load_type (r_ldType),
    .result    (w_alignResult)
  );

  // Next-state, handshake and memory-strobe decode. Requests are only taken
  // in IDLE, and the memory strobe for an accepted request is driven in the
  // same cycle straight from its address. Reset forces every combinational
  // output low so nothing escapes during the reset cycle.
  always_comb begin
    w_stateNext   = r_state;
    if_req_ready  = 1'b0;
    ld_req_ready  = 1'b0;
    mem_en        = 1'b0;
    mem_idx       = '0;
    w_acceptFetch = 1'b0;
    w_acceptLoad  = 1'b0;
    if (!rst) begin
      case (r_state)
        IDLE: begin
          if (w_grantFetch) begin
            if_req_ready  = 1'b1;
            w_acceptFetch = 1'b1;
            mem_en        = !w_ifOor;
            if (!w_ifOor) begin
              mem_idx = if_req_addr[IDX_W+1:2];
            end
            w_stateNext = FETCH_RSP;
          end else if (ld_req_valid) begin
            ld_req_ready = 1'b1;
            w_acceptLoad = 1'b1;
            mem_en       = !w_ldOor;
            if (!w_ldOor) begin
              mem_idx = ld_req_addr[IDX_W+1:2];
            end
            w_stateNext = w_ldCross ? LD_BEAT2 : LD_RSP;
          end
        end
        LD_BEAT2: begin
          mem_en = !w_beat2Oor;
          if (!w_beat2Oor) begin
            mem_idx = w_beat2Idx[IDX_W-1:0];
          end
          w_stateNext = LD_RSP;
        end
        FETCH_RSP, LD_RSP: w_stateNext = IDLE;
        default:           w_stateNext = IDLE;
      endcase
    end
  end

  // State, request capture and response registers. The starvation counter
  // keeps counting while the arbiter is busy because a fetch waiting behind
  // an in-flight load is still being starved. Response pulses default low
  // and are raised only on the cycle after the final data beat arrives.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_starveCnt  <= '0;
      r_wordIdx    <= '0;
      r_offset     <= '0;
      r_ldType     <= '0;
      r_split      <= 1'b0;
      r_oorFirst   <= 1'b0;
      r_oorSecond  <= 1'b0;
      r_holdWord   <= '0;
      r_ifRspValid <= 1'b0;
      r_ifRspData  <= '0;
      r_ldRspValid <= 1'b0;
      r_ldRspData  <= '0;
    end else begin
      r_state      <= w_stateNext;
      r_ifRspValid <= 1'b0;
      r_ldRspValid <= 1'b0;
      if (w_acceptFetch) begin
        r_starveCnt <= '0;
        r_oorFirst  <= w_ifOor;
        r_split     <= 1'b0;
      end else if (if_req_valid && (r_starveCnt != MAX_CNT)) begin
        r_starveCnt <= r_starveCnt + 1'b1;
      end
      if (w_acceptLoad) begin
        r_wordIdx  <= ld_req_addr[31:2];
        r_offset   <= ld_req_addr[1:0];
        r_ldType   <= ld_req_type;
        r_split    <= w_ldCross;
        r_oorFirst <= w_ldOor;
      end
      case (r_state)
        FETCH_RSP: begin
          r_ifRspValid <= 1'b1;
          r_ifRspData  <= r_oorFirst ? NOP_INSTR : mem_rdata;
        end
        LD_BEAT2: begin
          r_holdWord  <= w_beatData;
          r_oorSecond <= w_beat2Oor;
        end
        LD_RSP: begin
          r_ldRspValid <= 1'b1;
          r_ldRspData  <= w_alignResult;
        end
        default: begin
        end
      endcase
    end
  end

  assign if_rsp_valid = r_ifRspValid;
  assign if_rsp_data  = r_ifRspData;
  assign ld_rsp_valid = r_ldRspValid;
  assign ld_rsp_data  = r_ldRspData;

`ifdef IMEM_ARB_STATS_EN
  logic [31:0] r_statFetch;
  logic [31:0] r_statLoad;
  logic [31:0] r_statSplit;

  // Free-running wrap-around activity counters: every accepted fetch, every
  // accepted load, and the subset of loads that needed a second beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_statFetch <= '0;
      r_statLoad  <= '0;
      r_statSplit <= '0;
    end else begin
      if (w_acceptFetch) begin
        r_statFetch <= r_statFetch + 32'd1;
      end
      if (w_acceptLoad) begin
        r_statLoad <= r_statLoad + 32'd1;
      end
      if (w_acceptLoad && w_ldCross) begin
        r_statSplit <= r_statSplit + 32'd1;
      end
    end
  end

  assign stat_fetch_cnt = r_statFetch;
  assign stat_load_cnt  = r_statLoad;
  assign stat_split_cnt = r_statSplit;
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter
// Self-checking bench for imem_port_arbiter: a behavioural memory answers
// the read port, and expected fetch/load results, latencies and memory beats
// are derived from a byte-level view of that memory. Arbitration is checked
// against a model of how long the fetch has been kept waiting.
module tb_imem_port_arbiter;

  localparam int MEM_WORDS = 512;
  localparam int MAX_WAIT  = 4;
  localparam int IDX_W     = 9;

  logic             clk;
  logic             rst;
  logic             if_req_valid;
  logic [31:0]      if_req_addr;
  logic             if_req_ready;
  logic             if_rsp_valid;
  logic [31:0]      if_rsp_data;
  logic             ld_req_valid;
  logic [31:0]      ld_req_addr;
  logic [2:0]       ld_req_type;
  logic             ld_req_ready;
  logic             ld_rsp_valid;
  logic [31:0]      ld_rsp_data;
  logic             mem_en;
  logic [IDX_W-1:0] mem_idx;
  logic [31:0]      mem_rdata;
`ifdef IMEM_ARB_STATS_EN
  logic [31:0]      stat_fetch_cnt;
  logic [31:0]      stat_load_cnt;
  logic [31:0]      stat_split_cnt;
`endif

  logic [31:0] memArr [0:MEM_WORDS-1];
  int          memLog[$];
  int          cycle;
  int          starveModel;
  int          total;
  int          bad;

  imem_port_arbiter #(
    .MEM_WORDS (MEM_WORDS),
    .MAX_WAIT  (MAX_WAIT),
    .IDX_W     (IDX_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .if_req_valid (if_req_valid),
    .if_req_addr  (if_req_addr),
    .if_req_ready (if_req_ready),
    .if_rsp_valid (if_rsp_valid),
    .if_rsp_data  (if_rsp_data),
    .ld_req_valid (ld_req_valid),
    .ld_req_addr  (ld_req_addr),
    .ld_req_type  (ld_req_type),
    .ld_req_ready (ld_req_ready),
    .ld_rsp_valid (ld_rsp_valid),
    .ld_rsp_data  (ld_rsp_data),
    .mem_en       (mem_en),
    .mem_idx      (mem_idx),
    .mem_rdata    (mem_rdata)
`ifdef IMEM_ARB_STATS_EN
    ,
    .stat_fetch_cnt (stat_fetch_cnt),
    .stat_load_cnt  (stat_load_cnt),
    .stat_split_cnt (stat_split_cnt)
`endif
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous memory: data for a strobed index appears the next cycle.
  always @(posedge clk) begin
    cycle <= cycle + 1;
    if (mem_en) begin
      mem_rdata <= memArr[mem_idx];
    end
  end

  // Record every memory strobe so transactions can check their beats.
  always @(negedge clk) begin
    if (mem_en) begin
      memLog.push_back(int'(mem_idx));
    end
  end

  // One comparison: count it, report it if it differs.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Arbitration model: the fetch has priority once it has gone MAX_WAIT
  // cycles valid without being taken; until then a competing load wins.
  always @(negedge clk) begin
    if (rst) begin
      starveModel = 0;
    end else begin
      if (if_req_valid && ld_req_valid && (if_req_ready || ld_req_ready)) begin
        checkOutput("arbGrant", {30'd0, if_req_ready, ld_req_ready},
                    (starveModel >= MAX_WAIT) ? 32'd2 : 32'd1);
      end
      if (if_req_valid && if_req_ready) begin
        starveModel = 0;
      end else if (if_req_valid && starveModel < MAX_WAIT) begin
        starveModel++;
      end
    end
  end

  function automatic logic [7:0] byteAt(input logic [31:0] a);
    logic [31:0] word;
    if (int'(a >> 2) >= MEM_WORDS) return 8'h00;
    word = memArr[int'(a >> 2)];
    return word[8*a[1:0] +: 8];
  endfunction

  function automatic int sizeOf(input logic [2:0] ty);
    case (ty)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  // Little-endian byte gather followed by extension; unknown types give 0.
  function automatic logic [31:0] modelLoad(input logic [31:0] addr, input logic [2:0] ty);
    logic [31:0] v;
    int size;
    bit isSigned;
    size = sizeOf(ty);
    isSigned = (ty == 3'b000) || (ty == 3'b001);
    v = '0;
    if (size == 0) return 32'h0;
    for (int i = 0; i < size; i++) v[8*i +: 8] = byteAt(addr + i);
    if (isSigned && v[8*size-1]) begin
      for (int i = size; i < 4; i++) v[8*i +: 8] = 8'hFF;
    end
    return v;
  endfunction

  // Issue one request on the chosen port, wait (bounded) for its acceptance
  // and response, and compare data, latency, memory beats and pulse shape.
  task automatic applyStimulus(input bit isFetch, input logic [31:0] addr, input logic [2:0] ty);
    int firstW, lastW, expLat, acceptCycle, rspCycle, size;
    int expIdx[$];
    logic [31:0] expData, rspData;
    bit got, otherPulse;
    size    = isFetch ? 4 : ((sizeOf(ty) == 0) ? 1 : sizeOf(ty));
    firstW  = isFetch ? int'(addr >> 2) : int'(addr >> 2);
    lastW   = isFetch ? firstW : int'((addr + size - 1) >> 2);
    expLat  = (lastW != firstW) ? 3 : 2;
    if (isFetch) expData = (firstW < MEM_WORDS) ? memArr[firstW] : 32'h00000013;
    else         expData = modelLoad(addr, ty);
    for (int w = firstW; w <= lastW; w++) if (w < MEM_WORDS) expIdx.push_back(w);
    memLog.delete();
    otherPulse  = 0;
    acceptCycle = 0;
    rspCycle    = 0;
    rspData     = '0;
    @(posedge clk); #1;
    if (isFetch) begin
      if_req_valid = 1'b1; if_req_addr = addr;
    end else begin
      ld_req_valid = 1'b1; ld_req_addr = addr; ld_req_type = ty;
    end
    got = 0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (isFetch ? if_req_ready : ld_req_ready) begin
        got = 1; acceptCycle = cycle;
      end
    end
    checkOutput(isFetch ? "fetchAccept" : "loadAccept", {31'd0, got}, 32'd1);
    @(posedge clk); #1;
    if_req_valid = 1'b0;
    ld_req_valid = 1'b0;
    if (!got) return;
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (isFetch ? ld_rsp_valid : if_rsp_valid) otherPulse = 1;
      if (isFetch ? if_rsp_valid : ld_rsp_valid) begin
        got = 1; rspCycle = cycle; rspData = isFetch ? if_rsp_data : ld_rsp_data;
      end
    end
    checkOutput("rspSeen", {31'd0, got}, 32'd1);
    if (!got) return;
    checkOutput(isFetch ? "fetchData" : "loadData", rspData, expData);
    checkOutput("latency", 32'(rspCycle - acceptCycle), 32'(expLat));
    checkOutput("otherRspQuiet", {31'd0, otherPulse}, 32'd0);
    checkOutput("beatCount", 32'(memLog.size()), 32'(expIdx.size()));
    for (int i = 0; i < expIdx.size() && i < memLog.size(); i++)
      checkOutput("beatIdx", 32'(memLog[i]), 32'(expIdx[i]));
    @(negedge clk);
    checkOutput("pulseOneCycle", {31'd0, isFetch ? if_rsp_valid : ld_rsp_valid}, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int fetchAcc, loadRun, maxRun;
    bit got;
    logic [31:0] a;
    logic [2:0]  t;
    total = 0; bad = 0; cycle = 0; starveModel = 0;
    mem_rdata = '0;
    for (int i = 0; i < MEM_WORDS; i++) memArr[i] = $urandom();
    memArr[0] = 32'h00000013;
    memArr[1] = 32'h11223344;
    memArr[2] = 32'hAABBCCDD;

    // Reset with both requesters asserting: nothing may leak out.
    rst = 1'b1;
    if_req_valid = 1'b1; if_req_addr = 32'h4;
    ld_req_valid = 1'b1; ld_req_addr = 32'h8; ld_req_type = 3'b010;
    repeat (3) @(negedge clk);
    checkOutput("rstIfReady", {31'd0, if_req_ready}, 32'd0);
    checkOutput("rstLdReady", {31'd0, ld_req_ready}, 32'd0);
    checkOutput("rstMemEn",   {31'd0, mem_en}, 32'd0);
    checkOutput("rstMemIdx",  32'(mem_idx), 32'd0);
    checkOutput("rstIfRsp",   {31'd0, if_rsp_valid}, 32'd0);
    checkOutput("rstIfData",  if_rsp_data, 32'd0);
    checkOutput("rstLdRsp",   {31'd0, ld_rsp_valid}, 32'd0);
    checkOutput("rstLdData",  ld_rsp_data, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; if_req_valid = 1'b0; ld_req_valid = 1'b0;
    @(negedge clk);

    $display("[TB] directed transactions");
    applyStimulus(1, 32'h004, 3'b000);
    applyStimulus(0, 32'h009, 3'b000);
    applyStimulus(0, 32'h009, 3'b100);
    applyStimulus(0, 32'h006, 3'b001);
    applyStimulus(0, 32'h006, 3'b010);
    applyStimulus(0, 32'h007, 3'b001);
    applyStimulus(0, 32'h007, 3'b101);
    applyStimulus(0, 32'h005, 3'b010);
    applyStimulus(0, 32'h004, 3'b011);
    applyStimulus(1, 32'h800, 3'b000);
    applyStimulus(0, 32'h7FE, 3'b010);
    applyStimulus(0, 32'h7FF, 3'b001);
    applyStimulus(0, 32'h805, 3'b010);

    $display("[TB] random transactions");
    for (int r = 0; r < 60; r++) begin
      case ($urandom_range(0, 2))
        0:       a = 32'($urandom_range(0, 'h3F));
        1:       a = 32'($urandom_range('h7F0, 'h80F));
        default: a = 32'($urandom_range('h40, 'hFFF));
      endcase
      t = 3'($urandom_range(0, 7));
      applyStimulus($urandom_range(0, 9) < 3, a, t);
    end

    $display("[TB] arbitration under contention");
    fetchAcc = 0; loadRun = 0; maxRun = 0;
    @(posedge clk); #1;
    if_req_valid = 1'b1; if_req_addr = 32'h4;
    ld_req_valid = 1'b1; ld_req_addr = 32'h8; ld_req_type = 3'b010;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (if_req_ready) begin
        fetchAcc++; loadRun = 0;
      end else if (ld_req_ready) begin
        loadRun++;
        if (loadRun > maxRun) maxRun = loadRun;
      end
    end
    @(posedge clk); #1;
    if_req_valid = 1'b0; ld_req_valid = 1'b0;
    checkOutput("arbFetchSeen", {31'd0, fetchAcc > 0}, 32'd1);
    checkOutput("arbMaxLoadRun", {31'd0, maxRun <= MAX_WAIT}, 32'd1);
    repeat (5) @(negedge clk);

    $display("[TB] reset during split load");
    @(posedge clk); #1;
    ld_req_valid = 1'b1; ld_req_addr = 32'h5; ld_req_type = 3'b010;
    @(negedge clk);
    checkOutput("splitAccept", {31'd0, ld_req_ready}, 32'd1);
    @(posedge clk); #1;
    ld_req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    checkOutput("rstBeat2MemEn", {31'd0, mem_en}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0; if_req_valid = 1'b1; if_req_addr = 32'h4;
    @(negedge clk);
    checkOutput("postRstLdRsp",  {31'd0, ld_rsp_valid}, 32'd0);
    checkOutput("postRstLdData", ld_rsp_data, 32'd0);
    checkOutput("postRstIfRsp",  {31'd0, if_rsp_valid}, 32'd0);
    checkOutput("postRstFetchReady", {31'd0, if_req_ready}, 32'd1);
    @(posedge clk); #1;
    if_req_valid = 1'b0;
    got = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (ld_rsp_valid) checkOutput("droppedLoadQuiet", {31'd0, ld_rsp_valid}, 32'd0);
      if (if_rsp_valid) begin
        got = 1;
        checkOutput("postRstFetchData", if_rsp_data, 32'h11223344);
      end
    end
    checkOutput("postRstFetchRsp", {31'd0, got}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
